// File: rtl/block_memory_responder.sv
// Main-memory responder for the cache block interface: one request at a time,
// with fixed read/write latency into an internal block array.
module block_memory_responder #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned BLOCK_BITS    = 512,
    parameter int unsigned DEPTH_BLOCKS  = 256,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BLOCK_BITS-1:0] mem_write_data,
    output logic [BLOCK_BITS-1:0] mem_read_data,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  protocol_err
);

    localparam int unsigned OFFSET_BITS = $clog2(BLOCK_BITS / 8);
    localparam int unsigned IDX_BITS    = $clog2(DEPTH_BLOCKS);
    localparam int unsigned IDX_HI      = OFFSET_BITS + IDX_BITS - 1;
    localparam int unsigned MAX_LAT     = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                         : WRITE_LATENCY;
    localparam int unsigned CNT_BITS    = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

    localparam logic [CNT_BITS-1:0] READ_LOAD  = CNT_BITS'(READ_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] WRITE_LOAD = CNT_BITS'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReadWait,
        StWriteWait,
        StRespond
    } state_e;

    state_e                state_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic                  armed_q;
    logic                  op_write_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic [BLOCK_BITS-1:0] wdata_q;
    logic [BLOCK_BITS-1:0] mem_array [DEPTH_BLOCKS];

    logic [IDX_BITS-1:0] idx;
    logic                req_dropped;
    logic                commit;
    logic                unused_addr_bits;

    assign idx              = mem_addr[IDX_HI:OFFSET_BITS];
    assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:IDX_HI+1], mem_addr[OFFSET_BITS-1:0]};
    assign req_dropped      = op_write_q ? !mem_write : !mem_read;
    // Reset forces StIdle asynchronously, so an aborted write never reaches here.
    assign commit           = (state_q == StWriteWait) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_array[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            armed_q       <= 1'b1;
            op_write_q    <= 1'b0;
            idx_q         <= '0;
            wdata_q       <= '0;
            mem_read_data <= '0;
            mem_ready     <= 1'b0;
            busy          <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!armed_q) begin
                        // Wait for the requester to drop the completed request.
                        if (!mem_read && !mem_write) begin
                            armed_q <= 1'b1;
                        end
                    end else if (mem_write) begin
                        idx_q      <= idx;
                        wdata_q    <= mem_write_data;
                        cnt_q      <= WRITE_LOAD;
                        op_write_q <= 1'b1;
                        busy       <= 1'b1;
                        state_q    <= StWriteWait;
                        if (mem_read) begin
                            protocol_err <= 1'b1;
                        end
                    end else if (mem_read) begin
                        idx_q      <= idx;
                        cnt_q      <= READ_LOAD;
                        op_write_q <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= StReadWait;
                    end
                end
                StReadWait, StWriteWait: begin
                    if (req_dropped) begin
                        protocol_err <= 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (state_q == StReadWait) begin
                            mem_read_data <= mem_array[idx_q];
                        end
                        mem_ready <= 1'b1;
                        state_q   <= StRespond;
                    end
                end
                StRespond: begin
                    if (req_dropped) begin
                        protocol_err <= 1'b1;
                    end
                    busy    <= 1'b0;
                    armed_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_block_memory_responder.sv
// Bench for block_memory_responder: two instances (4/4 and 1/7 latency) share stimulus
// and are checked against an array-based model of block storage and handshake timing.
module tb_block_memory_responder;

    localparam int AW = 32;
    localparam int BB = 512;

    logic          clk;
    logic          reset;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [BB-1:0] mem_write_data;

    logic [BB-1:0] rdata_a, rdata_b;
    logic          ready_a, ready_b, busy_a, busy_b, err_a, err_b;

    int checks;
    int failures;

    logic [BB-1:0] model_mem [256];
    int            written[$];
    logic [BB-1:0] rdata_exp;
    logic          err_exp;

    block_memory_responder dut_a (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (rdata_a),
        .mem_ready      (ready_a),
        .busy           (busy_a),
        .protocol_err   (err_a)
    );

    block_memory_responder #(
        .READ_LATENCY  (1),
        .WRITE_LATENCY (7)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (rdata_b),
        .mem_ready      (ready_b),
        .busy           (busy_b),
        .protocol_err   (err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [BB-1:0] rand_block();
        logic [BB-1:0] blk;
        for (int i = 0; i < BB / 32; i++) blk[i*32 +: 32] = $urandom;
        return blk;
    endfunction

    function automatic int idx_of(input logic [AW-1:0] addr);
        return int'(addr[13:6]);
    endfunction

    // Issue one request, hold it until both instances have completed (plus hold_extra
    // cycles), then drop it; checks latency, pulse count, busy span, data and error.
    task automatic run_txn(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [BB-1:0] data, input int hold_extra, input string name);
        int lat_a, lat_b, stop;
        int first_a, first_b, pulses_a, pulses_b, busy_na, busy_nb;
        lat_a    = 4;
        lat_b    = wr ? 7 : 1;
        stop     = ((lat_a > lat_b) ? lat_a : lat_b) + 2 + hold_extra;
        first_a  = 0;
        first_b  = 0;
        pulses_a = 0;
        pulses_b = 0;
        busy_na  = 0;
        busy_nb  = 0;
        @(negedge clk);
        mem_read       = rd;
        mem_write      = wr;
        mem_addr       = addr;
        mem_write_data = data;
        for (int k = 1; k <= stop; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_a) begin
                pulses_a++;
                if (first_a == 0) first_a = k;
            end
            if (ready_b) begin
                pulses_b++;
                if (first_b == 0) first_b = k;
            end
            if (busy_a) busy_na++;
            if (busy_b) busy_nb++;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;

        if (wr) begin
            model_mem[idx_of(addr)] = data;
            written.push_back(idx_of(addr));
            if (rd) err_exp = 1'b1;
        end else if (rd) begin
            rdata_exp = model_mem[idx_of(addr)];
        end

        checks++;
        if (first_a !== lat_a + 1) begin
            failures++;
            $display("FAIL %s a_latency: got cycle %0d, want %0d", name, first_a, lat_a + 1);
        end
        checks++;
        if (first_b !== lat_b + 1) begin
            failures++;
            $display("FAIL %s b_latency: got cycle %0d, want %0d", name, first_b, lat_b + 1);
        end
        checks++;
        if (pulses_a !== 1 || pulses_b !== 1) begin
            failures++;
            $display("FAIL %s pulses: got a=%0d b=%0d, want 1 each", name, pulses_a, pulses_b);
        end
        checks++;
        if (busy_na !== lat_a + 1 || busy_nb !== lat_b + 1) begin
            failures++;
            $display("FAIL %s busy_span: got a=%0d b=%0d, want a=%0d b=%0d", name,
                     busy_na, busy_nb, lat_a + 1, lat_b + 1);
        end
        checks++;
        if (rdata_a !== rdata_exp || rdata_b !== rdata_exp) begin
            failures++;
            $display("FAIL %s rdata: got a=%h b=%h, want %h", name, rdata_a, rdata_b, rdata_exp);
        end
        checks++;
        if (err_a !== err_exp || err_b !== err_exp) begin
            failures++;
            $display("FAIL %s protocol_err: got a=%b b=%b, want %b", name, err_a, err_b, err_exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        rdata_exp      = '0;
        err_exp        = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready_a, busy_a, err_a, ready_b, busy_b, err_b} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b, want 000000",
                     {ready_a, busy_a, err_a, ready_b, busy_b, err_b});
        end
        checks++;
        if (rdata_a !== '0 || rdata_b !== '0) begin
            failures++;
            $display("FAIL reset_rdata: got a=%h b=%h, want 0", rdata_a, rdata_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_readback();
        run_txn(1'b0, 1'b1, 32'h0000_0040, {16{32'hDEADBEEF}}, 0, "wb_write");
        run_txn(1'b1, 1'b0, 32'h0000_0040, '0, 0, "wb_read");
        checks++;
        if (rdata_a !== {16{32'hDEADBEEF}}) begin
            failures++;
            $display("FAIL wb_value: got %h, want DEADBEEF pattern", rdata_a);
        end
    endtask

    task automatic test_alias();
        logic [BB-1:0] pat_a;
        pat_a = rand_block();
        run_txn(1'b0, 1'b1, 32'h0000_007C, pat_a, 0, "alias_write");
        run_txn(1'b1, 1'b0, 32'h0000_4040, '0, 0, "alias_read");
    endtask

    task automatic test_held_request();
        run_txn(1'b1, 1'b0, 32'h0000_0040, '0, 3, "held_read");
        run_txn(1'b1, 1'b0, 32'h0000_0040, '0, 0, "reassert_read");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [AW-1:0] addr;
            int            idx;
            if (written.size() == 0 || $urandom_range(0, 1) == 0) idx = $urandom_range(0, 15);
            else idx = written[$urandom_range(0, written.size() - 1)];
            addr = {$urandom_range(0, 262143), 8'(idx), 6'($urandom_range(0, 63))};
            if (written.size() == 0 || $urandom_range(0, 1) == 0 || !(idx inside {written}))
                run_txn(1'b0, 1'b1, addr, rand_block(), $urandom_range(0, 2), "rand_write");
            else
                run_txn(1'b1, 1'b0, addr, '0, $urandom_range(0, 2), "rand_read");
        end
    endtask

    task automatic test_simultaneous();
        logic [BB-1:0] pat_b;
        pat_b = rand_block();
        run_txn(1'b1, 1'b1, 32'h0000_0080, pat_b, 0, "both_req");
        run_txn(1'b1, 1'b0, 32'h0000_0080, '0, 0, "both_readback");
    endtask

    task automatic test_reset_mid_write();
        run_txn(1'b0, 1'b1, 32'h0000_00C0, rand_block(), 0, "mid_seed");
        @(negedge clk);
        mem_write      = 1'b1;
        mem_addr       = 32'h0000_00C0;
        mem_write_data = rand_block();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({ready_a, busy_a, err_a, ready_b, busy_b, err_b} !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset_flags: got %b, want 000000",
                     {ready_a, busy_a, err_a, ready_b, busy_b, err_b});
        end
        mem_write = 1'b0;
        rdata_exp = '0;
        err_exp   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_txn(1'b1, 1'b0, 32'h0000_00C0, '0, 0, "mid_readback");
    endtask

    task automatic test_drop_request();
        int pulses_a, pulses_b;
        pulses_a = 0;
        pulses_b = 0;
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 32'h0000_0040;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (ready_a) pulses_a++;
            if (ready_b) pulses_b++;
            @(negedge clk);
        end
        rdata_exp = model_mem[idx_of(32'h0000_0040)];
        checks++;
        if (pulses_a !== 1 || pulses_b !== 1) begin
            failures++;
            $display("FAIL drop_pulses: got a=%0d b=%0d, want 1 each", pulses_a, pulses_b);
        end
        checks++;
        if (err_a !== 1'b1 || err_b !== 1'b1) begin
            failures++;
            $display("FAIL drop_err: got a=%b b=%b, want 1", err_a, err_b);
        end
        checks++;
        if (rdata_a !== rdata_exp || rdata_b !== rdata_exp) begin
            failures++;
            $display("FAIL drop_rdata: got a=%h b=%h, want %h", rdata_a, rdata_b, rdata_exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_readback();
        test_alias();
        test_held_request();
        test_random();
        test_simultaneous();
        test_reset_mid_write();
        test_drop_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
